fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pr_f_d.sv | 38 +++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: widths, NOP encoding, fetch FSM state type.
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HELD  = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_e;

   // Sequential PC step; wraps modulo 2^32 by construction.
   function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pr_f_d.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load or bubble.
module pr_f_d
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               load,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [PC_W-1:0]    pcplus4_in,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pcplus4,
   output logic               valid
);

   // A bubble clears instr/valid but leaves pcplus4 as it was.
   always_ff @(posedge clk) begin
      if (!reset) begin
         instr   <= NOP_INSTR;
         pcplus4 <= '0;
         valid   <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (!stall) begin
         if (load) begin
            instr   <= instr_in;
            pcplus4 <= pcplus4_in;
            valid   <= 1'b1;
         end else begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, redirect handling and FETCH/HELD/DRAIN sequencing.
// Optional FETCH_PERF_EN adds wait-cycle and redirect counters.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_d,
   input  logic               flush_d,
   input  logic               pcsrc_d,
   input  logic [PC_W-1:0]    pcbranch_d,
   input  logic               jump_d,
   input  logic [PC_W-1:0]    jumpaddr_d,
   input  logic               jr_d,
   input  logic [PC_W-1:0]    jrtarget_d,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_d,
   output logic [PC_W-1:0]    pcplus4_d,
   output logic               valid_d,
   output logic [PC_W-1:0]    pc_f,
   output logic [1:0]         fetch_state
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_wait_cnt,
   output logic [31:0]        perf_redirect_cnt
`endif
);

   fetch_state_e       state;
   logic [INSTR_W-1:0] hold_instr;
   logic [PC_W-1:0]    hold_pc4;
   logic [PC_W-1:0]    kill_addr;
   logic               redirect;
   logic [PC_W-1:0]    target;
   logic [PC_W-1:0]    pc_plus4;
   logic               load;
   logic [INSTR_W-1:0] load_instr;
   logic [PC_W-1:0]    load_pc4;

   assign redirect    = pcsrc_d | jump_d | jr_d;
   assign target      = jr_d ? jrtarget_d : (jump_d ? jumpaddr_d : pcbranch_d);
   assign pc_plus4    = pc_next(pc_f);
   assign fetch_state = state;

   // HELD parks the bus; DRAIN keeps presenting the abandoned address until it completes.
   assign imem_req  = (state != S_HELD);
   assign imem_addr = (state == S_DRAIN) ? kill_addr : pc_f;

   // Only a non-redirected fetch or a parked instruction may enter IF/ID.
   assign load       = !redirect && (((state == S_FETCH) && imem_ready) || (state == S_HELD));
   assign load_instr = (state == S_HELD) ? hold_instr : imem_rdata;
   assign load_pc4   = (state == S_HELD) ? hold_pc4 : pc_plus4;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_FETCH;
         pc_f       <= RESET_PC;
         hold_instr <= '0;
         hold_pc4   <= '0;
         kill_addr  <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (redirect) begin
                  pc_f <= target;
                  if (!imem_ready) begin
                     kill_addr <= pc_f;
                     state     <= S_DRAIN;
                  end
               end else if (imem_ready) begin
                  pc_f <= pc_plus4;
                  if (stall_d) begin
                     hold_instr <= imem_rdata;
                     hold_pc4   <= pc_plus4;
                     state      <= S_HELD;
                  end
               end
            end
            S_HELD: begin
               if (redirect) begin
                  pc_f  <= target;
                  state <= S_FETCH;
               end else if (!stall_d) begin
                  state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               if (redirect) pc_f <= target;
               if (imem_ready) state <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   pr_f_d u_pr_f_d (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall_d),
      .flush      (flush_d),
      .load       (load),
      .instr_in   (load_instr),
      .pcplus4_in (load_pc4),
      .instr      (instr_d),
      .pcplus4    (pcplus4_d),
      .valid      (valid_d)
   );

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_wait_cnt     <= '0;
         perf_redirect_cnt <= '0;
      end else begin
         if (imem_req && !imem_ready) perf_wait_cnt <= perf_wait_cnt + 32'd1;
         if (redirect) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end
   end
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based reference model checked every cycle.
module tb_fetch_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset, stall_d, flush_d, pcsrc_d, jump_d, jr_d, imem_ready;
   logic [31:0] pcbranch_d, jumpaddr_d, jrtarget_d;
   logic [31:0] imem_rdata;
   logic        imem_req, valid_d;
   logic [31:0] imem_addr, instr_d, pcplus4_d, pc_f;
   logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_wait_cnt, perf_redirect_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Memory image: every word encodes its own address.
   assign imem_rdata = {8'hA0, imem_addr[23:0]};

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .stall_d(stall_d), .flush_d(flush_d),
      .pcsrc_d(pcsrc_d), .pcbranch_d(pcbranch_d), .jump_d(jump_d), .jumpaddr_d(jumpaddr_d),
      .jr_d(jr_d), .jrtarget_d(jrtarget_d), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_d(instr_d),
      .pcplus4_d(pcplus4_d), .valid_d(valid_d), .pc_f(pc_f), .fetch_state(fetch_state)
`ifdef FETCH_PERF_EN
      , .perf_wait_cnt(perf_wait_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: parked fetches and abandoned requests are tracked as queues.
   logic [31:0] m_pc, m_instr, m_pc4, m_wait, m_redir;
   logic        m_valid;
   logic [63:0] m_held_q[$];
   logic [31:0] m_kill_q[$];
   bit          started = 0;

   always @(posedge clk) begin : model
      logic        redir, give;
      logic [31:0] tgt, gi, gp;
      if (!reset) begin
         started = 1;
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_wait = 0; m_redir = 0;
         m_held_q.delete();
         m_kill_q.delete();
      end else begin
         redir = pcsrc_d | jump_d | jr_d;
         tgt   = jr_d ? jrtarget_d : (jump_d ? jumpaddr_d : pcbranch_d);
         give  = 1'b0; gi = 32'h0; gp = 32'h0;
         if (m_held_q.size() == 0 && !imem_ready) m_wait = m_wait + 1;
         if (redir) m_redir = m_redir + 1;
         if (m_kill_q.size() != 0) begin
            if (redir) m_pc = tgt;
            if (imem_ready) void'(m_kill_q.pop_front());
         end else if (m_held_q.size() != 0) begin
            if (redir) begin
               m_held_q.delete();
               m_pc = tgt;
            end else if (!stall_d) begin
               {gi, gp} = m_held_q.pop_front();
               give = 1'b1;
            end
         end else begin
            if (redir) begin
               if (!imem_ready) m_kill_q.push_back(m_pc);
               m_pc = tgt;
            end else if (imem_ready) begin
               if (stall_d) m_held_q.push_back({imem_rdata, m_pc + 32'd4});
               else begin
                  give = 1'b1; gi = imem_rdata; gp = m_pc + 32'd4;
               end
               m_pc = m_pc + 32'd4;
            end
         end
         if (flush_d) begin
            m_instr = 32'h0; m_valid = 1'b0;
         end else if (!stall_d) begin
            if (give) begin
               m_instr = gi; m_pc4 = gp; m_valid = 1'b1;
            end else begin
               m_instr = 32'h0; m_valid = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      fetch_state_e es;
      if (started) begin
         es = (m_kill_q.size() != 0) ? S_DRAIN : ((m_held_q.size() != 0) ? S_HELD : S_FETCH);
         chk("cyc_state", 32'(fetch_state), 32'(es));
         chk("cyc_pc_f", pc_f, m_pc);
         chk("cyc_imem_req", 32'(imem_req), 32'(m_held_q.size() == 0));
         chk("cyc_imem_addr", imem_addr, (m_kill_q.size() != 0) ? m_kill_q[0] : m_pc);
         chk("cyc_instr_d", instr_d, m_instr);
         chk("cyc_pcplus4_d", pcplus4_d, m_pc4);
         chk("cyc_valid_d", 32'(valid_d), 32'(m_valid));
`ifdef FETCH_PERF_EN
         chk("cyc_perf_wait", perf_wait_cnt, m_wait);
         chk("cyc_perf_redirect", perf_redirect_cnt, m_redir);
`endif
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      stall_d = 0; flush_d = 0; pcsrc_d = 0; jump_d = 0; jr_d = 0;
   endtask

   initial begin
      reset = 0; imem_ready = 1;
      pcbranch_d = 0; jumpaddr_d = 0; jrtarget_d = 0;
      idle();
      step(2);
      chk("rst_pc_f", pc_f, 32'h0);
      chk("rst_valid", 32'(valid_d), 32'h0);
      chk("rst_instr", instr_d, 32'h0);
      chk("rst_state", 32'(fetch_state), 32'(S_FETCH));

      // Straight-line fetch from reset.
      reset = 1;
      step(1);
      chk("seq_pc4", pc_f, 32'h4);
      chk("seq_instr0", instr_d, 32'hA000_0000);
      chk("seq_valid", 32'(valid_d), 32'h1);
      step(1);
      chk("seq_pc8", pc_f, 32'h8);
      chk("seq_instr1", instr_d, 32'hA000_0004);

      // jr outranks jump and branch.
      jr_d = 1; jrtarget_d = 32'h200; jump_d = 1; jumpaddr_d = 32'h80; pcsrc_d = 1; pcbranch_d = 32'h40;
      step(1);
      idle();
      chk("jr_pc", pc_f, 32'h200);
      chk("jr_bubble_valid", 32'(valid_d), 32'h0);
      chk("jr_bubble_pc4", pcplus4_d, 32'h8);

      // Stall parks the returned word.
      reset = 0; step(1);
      reset = 1; stall_d = 1;
      step(2);
      chk("held_state", 32'(fetch_state), 32'(S_HELD));
      chk("held_req", 32'(imem_req), 32'h0);
      chk("held_pc", pc_f, 32'h4);
      stall_d = 0;
      step(1);
      chk("held_instr", instr_d, 32'hA000_0000);
      chk("held_pc4", pcplus4_d, 32'h4);
      chk("held_valid", 32'(valid_d), 32'h1);

      // Jump beats branch; IF/ID gets a bubble.
      pcsrc_d = 1; pcbranch_d = 32'h40; jump_d = 1; jumpaddr_d = 32'h80;
      step(1);
      idle();
      chk("jmp_pc", pc_f, 32'h80);
      chk("jmp_instr", instr_d, 32'h0);
      chk("jmp_valid", 32'(valid_d), 32'h0);
      step(1);
      chk("jmp_fetch", instr_d, 32'hA000_0080);

      // Flush overrides stall.
      stall_d = 1; flush_d = 1;
      step(1);
      chk("flush_valid", 32'(valid_d), 32'h0);
      chk("flush_instr", instr_d, 32'h0);
      idle();
      step(1);
      chk("flush_release", instr_d, 32'hA000_0084);

      // Redirect while HELD drops the parked word.
      stall_d = 1;
      step(1);
      stall_d = 0; jump_d = 1; jumpaddr_d = 32'h500;
      step(1);
      idle();
      chk("hdrop_pc", pc_f, 32'h500);
      step(1);
      chk("hdrop_instr", instr_d, 32'hA000_0500);

      // Redirect with a pending fetch drains the old address first.
      reset = 0; step(1);
      reset = 1; step(2);
      imem_ready = 0; pcsrc_d = 1; pcbranch_d = 32'h100;
      step(1);
      idle();
      chk("drain_state", 32'(fetch_state), 32'(S_DRAIN));
      chk("drain_addr", imem_addr, 32'h8);
      step(2);
      chk("drain_addr_hold", imem_addr, 32'h8);
      imem_ready = 1;
      step(1);
      chk("drain_done_valid", 32'(valid_d), 32'h0);
      chk("drain_next_addr", imem_addr, 32'h100);
      step(1);
      chk("drain_fetch", instr_d, 32'hA000_0100);
      chk("drain_fetch_pc4", pcplus4_d, 32'h104);

      // Further redirects during DRAIN move only the PC.
      imem_ready = 0; jump_d = 1; jumpaddr_d = 32'h600;
      step(1);
      idle(); pcsrc_d = 1; pcbranch_d = 32'h700;
      step(1);
      idle();
      chk("drain2_addr", imem_addr, 32'h104);
      imem_ready = 1;
      step(1);
      chk("drain2_next", imem_addr, 32'h700);

      // PC wraps at 2^32.
      jump_d = 1; jumpaddr_d = 32'hFFFF_FFFC;
      step(1);
      idle();
      step(1);
      chk("wrap_pc", pc_f, 32'h0);
      chk("wrap_pc4", pcplus4_d, 32'h0);
      chk("wrap_instr", instr_d, 32'hA0FF_FFFC);

      // Reset in the middle of DRAIN.
      imem_ready = 0; pcsrc_d = 1; pcbranch_d = 32'h100;
      step(1);
      idle();
      reset = 0;
      step(1);
      chk("rdrain_pc", pc_f, 32'h0);
      chk("rdrain_state", 32'(fetch_state), 32'(S_FETCH));
      chk("rdrain_pc4", pcplus4_d, 32'h0);
      reset = 1; imem_ready = 1;
      step(1);
      chk("rdrain_fetch", instr_d, 32'hA000_0000);

`ifdef FETCH_PERF_EN
      reset = 0; step(1);
      reset = 1; imem_ready = 0;
      step(3);
      imem_ready = 1; jump_d = 1; jumpaddr_d = 32'h40;
      step(1);
      idle();
      step(1);
      jump_d = 1; jumpaddr_d = 32'h80;
      step(1);
      idle();
      chk("perf_wait", perf_wait_cnt, 32'd3);
      chk("perf_redirect", perf_redirect_cnt, 32'd2);
`else
      step(1);
`endif

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
